alu_seq: RTL



---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response channel bundle between a command source and the alu_seq front end.
// Master drives requests and consumes responses; slave is the alu_seq side.
interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_overflow, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential command front end for the external 32-bit combinational ALU.
// Define ALU_SEQ_MUL_EN to add the multi-pass unsigned multiply (opcode 1000).
//
// state | meaning
// IDLE  | ready for a request; ALU inputs hold the last operands
// EXEC  | single ALU op settling; result captured at the next edge
// MUL   | shift-and-add multiply, one adder pass per cycle
// DONE  | response held until rsp_ready
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;

`ifdef ALU_SEQ_MUL_EN
    localparam int             CW     = $clog2(WIDTH);
    localparam logic [OPW-1:0] OP_MUL = OPW'(8);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    iter_q, iter_d;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_err_d   = rsp_err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        iter_d      = iter_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    alu_a_d     = bus.req_a;
                    alu_b_d     = bus.req_b;
                    if (!bus.req_op[3]) begin
                        alu_op_d = bus.req_op[2:0];
                        state_d  = S_EXEC;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (bus.req_op == OP_MUL) begin
                        // ALU inputs carry the accumulator and shifted multiplicand from here on
                        acc_d    = '0;
                        mcand_d  = bus.req_a;
                        mplier_d = bus.req_b;
                        iter_d   = CW'(WIDTH - 1);
                        alu_a_d  = '0;
                        alu_b_d  = bus.req_a;
                        alu_op_d = 3'b010;
                        state_d  = S_MUL;
                    end
`endif
                    else begin
                        rsp_res_d   = '0;
                        rsp_zero_d  = 1'b1;
                        rsp_ovf_d   = 1'b0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end

            S_EXEC: begin
                rsp_res_d   = alu_res;
                rsp_zero_d  = alu_zero;
                rsp_ovf_d   = alu_overflow;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_DONE;
            end

`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                acc_d    = mplier_q[0] ? alu_res : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q - CW'(1);
                alu_a_d  = acc_d;
                alu_b_d  = mcand_d;
                if (mplier_d == '0 || iter_q == '0) begin
                    rsp_res_d   = acc_d;
                    rsp_zero_d  = (acc_d == '0);
                    rsp_ovf_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`endif

            S_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 3'b000;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            iter_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= rsp_err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            iter_q      <= iter_d;
`endif
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_res      = rsp_res_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_err      = rsp_err_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_op           = alu_op_q;

endmodule
